// File: rtl/scan_chain_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : scan_chain_if                                         |
// | Purpose  : command/response handshake bundle for scan_chain_ctrl |
// |            (pattern in, captured chain contents out)             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface scan_chain_if #(
   parameter int CHAIN_LEN = 32
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [CHAIN_LEN-1:0] cmd_data;
   logic [7:0]           cmd_cap_cycles;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [CHAIN_LEN-1:0] rsp_data;

   // Side that issues patterns and consumes responses
   modport master (
      output cmd_valid, cmd_data, cmd_cap_cycles, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   // Scan controller side
   modport slave (
      input  cmd_valid, cmd_data, cmd_cap_cycles, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : scan_chain_ctrl                                       |
// | Purpose  : drives scan_en/scan_in of a scan-instrumented core,   |
// |            shifts a CHAIN_LEN-bit pattern in while capturing the |
// |            previous chain contents from scan_out.                |
// | Options  : SCAN_CAPTURE_EN - when defined, holds scan_en low for |
// |            cmd_cap_cycles functional cycles after each shift.    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 32,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  wire logic   clk,
   input  wire logic   rst,
   scan_chain_if.slave bus,
   output logic        busy,
   output logic        scan_en,
   output logic        scan_in,
   input  wire logic   scan_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CHAIN_LEN-1:0] sh_in;
   logic [CHAIN_LEN-1:0] sh_out;
   logic [CHAIN_LEN-1:0] sh_out_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 accept;
   logic                 shift_last;

`ifdef SCAN_CAPTURE_EN
   logic [7:0]           cap_cnt;
`else
   // Capture length is meaningless without the CAPTURE state
   logic                 unused_cap_cycles;
   assign unused_cap_cycles = ^bus.cmd_cap_cycles;
`endif

   assign accept        = (state == S_IDLE) && bus.cmd_valid;
   assign shift_last    = (cnt == CNT_W'(CHAIN_LEN - 1));
   // Tail bit enters at the MSB so the first sampled bit ends at bit 0
   assign sh_out_nxt    = {scan_out, sh_out[CHAIN_LEN-1:1]};
   // sh_in is zero outside an active shift, so scan_in idles low
   assign scan_in       = sh_in[0];
   assign bus.cmd_ready = (state == S_IDLE);
   assign busy          = (state != S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.cmd_valid) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (shift_last) begin
`ifdef SCAN_CAPTURE_EN
               state_nxt = (cap_cnt != 8'd0) ? S_CAPTURE : S_RESP;
`else
               state_nxt = S_RESP;
`endif
            end
         end
         S_CAPTURE: begin
`ifdef SCAN_CAPTURE_EN
            if (cap_cnt == 8'd1) state_nxt = S_RESP;
`else
            state_nxt = S_IDLE;
`endif
         end
         S_RESP: begin
            if (bus.rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Shift datapath: pattern out, chain contents in, edge counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_in  <= '0;
         sh_out <= '0;
         cnt    <= '0;
      end else if (accept) begin
         sh_in  <= bus.cmd_data;
         sh_out <= '0;
         cnt    <= '0;
      end else if (state == S_SHIFT) begin
         sh_in  <= sh_in >> 1;
         sh_out <= sh_out_nxt;
         cnt    <= cnt + CNT_W'(1);
      end
   end

`ifdef SCAN_CAPTURE_EN
   // Functional-cycle countdown between shift and response
   always_ff @(posedge clk) begin
      if (rst)                     cap_cnt <= 8'd0;
      else if (accept)             cap_cnt <= bus.cmd_cap_cycles;
      else if (state == S_CAPTURE) cap_cnt <= cap_cnt - 8'd1;
   end
`endif

   // Registered outputs, derived from the upcoming state
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_en       <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
      end else begin
         scan_en       <= (state_nxt == S_SHIFT);
         bus.rsp_valid <= (state_nxt == S_RESP);
         if (state == S_SHIFT && state_nxt == S_RESP)
            bus.rsp_data <= sh_out_nxt;
         else if (state == S_CAPTURE && state_nxt == S_RESP)
            bus.rsp_data <= sh_out;
      end
   end

endmodule
`default_nettype wire
